// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RISC-V funct3 values, memory
// width codes and the sequencing FSM states.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   localparam logic [1:0] BW_BYTE   = 2'b00;
   localparam logic [1:0] BW_HALF   = 2'b01;
   localparam logic [1:0] BW_WORD   = 2'b10;
   localparam logic [1:0] BW_DOUBLE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/lsu_decode.sv
// Combinational funct3 decode: memory width code, sign control, access size
// in bytes and an illegal-encoding flag for loads and stores.
module lsu_decode
   import lsu_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic       i_is_store,
   output logic [1:0] o_bit_width,
   output logic       o_sign_extend,
   output logic [3:0] o_size,
   output logic       o_illegal
);

   always_comb begin
      o_bit_width   = BW_BYTE;
      o_sign_extend = 1'b0;
      o_illegal     = 1'b0;
      o_size        = 4'd1;
      case (i_funct3)
         F3_B:    begin o_bit_width = BW_BYTE;   o_sign_extend = 1'b1; end
         F3_H:    begin o_bit_width = BW_HALF;   o_sign_extend = 1'b1; end
         F3_W:    begin o_bit_width = BW_WORD;   o_sign_extend = 1'b1; end
         F3_D:    begin o_bit_width = BW_DOUBLE; o_sign_extend = 1'b1; end
         F3_BU:   begin o_bit_width = BW_BYTE;   o_sign_extend = 1'b0; end
         F3_HU:   begin o_bit_width = BW_HALF;   o_sign_extend = 1'b0; end
         F3_WU:   begin o_bit_width = BW_WORD;   o_sign_extend = 1'b0; end
         default: o_illegal = 1'b1;
      endcase
      // stores have no unsigned forms, so any funct3[2]=1 is illegal
      if (i_is_store) begin
         o_sign_extend = 1'b0;
         o_illegal     = i_funct3[2];
      end
      case (o_bit_width)
         BW_BYTE:   o_size = 4'd1;
         BW_HALF:   o_size = 4'd2;
         BW_WORD:   o_size = 4'd4;
         BW_DOUBLE: o_size = 4'd8;
         default:   o_size = 4'd1;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: decodes the op, computes and range
// checks the effective address, drives the data memory and returns a result.
//
// state   | meaning
// S_IDLE  | ready for a request; latches fields on req_valid
// S_ISSUE | one cycle with mem_en=1, mem_wea=is_store
// S_WAIT  | load only; READ_LATENCY cycles, captures mem_dout on the last
// S_RESP  | resp_valid held until resp_ready
module load_store_unit #(
   parameter int READ_LATENCY = 1,
   parameter int ADDR_BITS    = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_base,
   input  logic [63:0] req_offset,
   input  logic [63:0] req_store_data,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_fault,
   output logic        mem_en,
   output logic        mem_wea,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_din,
   output logic [1:0]  mem_bit_width,
   output logic        mem_sign_extend,
   input  logic [63:0] mem_dout
);
   import lsu_pkg::*;

   localparam logic [1:0] LAT = 2'(READ_LATENCY);

   logic [1:0]  w_bit_width;
   logic        w_sign_extend;
   logic [3:0]  w_size;
   logic        w_illegal;
   logic [64:0] w_sum;
   logic [64:0] w_last;
   logic        w_range_fault;

   lsu_state_t  r_state;
   logic        r_is_store;
   logic [1:0]  r_cnt;

   lsu_decode u_decode (
      .i_funct3      (req_funct3),
      .i_is_store    (req_is_store),
      .o_bit_width   (w_bit_width),
      .o_sign_extend (w_sign_extend),
      .o_size        (w_size),
      .o_illegal     (w_illegal)
   );

   // base is an unsigned address, offset a signed immediate: bit 64 set
   // means the sum wrapped below zero or above 2^64-1
   assign w_sum         = {1'b0, req_base} + {req_offset[63], req_offset};
   assign w_last        = {1'b0, w_sum[63:0]} + {61'd0, w_size} - 65'd1;
   assign w_range_fault = w_sum[64] || (w_last >= (65'd1 << ADDR_BITS));

   assign req_ready = (r_state == S_IDLE) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_is_store      <= 1'b0;
         r_cnt           <= 2'd0;
         resp_valid      <= 1'b0;
         resp_data       <= 64'd0;
         resp_rd         <= 5'd0;
         resp_fault      <= 1'b0;
         mem_en          <= 1'b0;
         mem_wea         <= 1'b0;
         mem_addr        <= 64'd0;
         mem_din         <= 64'd0;
         mem_bit_width   <= 2'd0;
         mem_sign_extend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  mem_addr        <= w_sum[63:0];
                  mem_din         <= req_store_data;
                  mem_bit_width   <= w_bit_width;
                  mem_sign_extend <= w_sign_extend;
                  r_is_store      <= req_is_store;
                  resp_rd         <= req_rd;
                  resp_data       <= 64'd0;
                  if (w_illegal || w_range_fault) begin
                     resp_fault <= 1'b1;
                     resp_valid <= 1'b1;
                     r_state    <= S_RESP;
                  end else begin
                     resp_fault <= 1'b0;
                     mem_en     <= 1'b1;
                     mem_wea    <= req_is_store;
                     r_state    <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               mem_wea <= 1'b0;
               if (r_is_store) begin
                  mem_en     <= 1'b0;
                  resp_valid <= 1'b1;
                  r_state    <= S_RESP;
               end else begin
                  r_cnt   <= LAT;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 2'd1) begin
                  resp_data  <= mem_dout;
                  mem_en     <= 1'b0;
                  resp_valid <= 1'b1;
                  r_state    <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-addressed memory model that
// honours READ_LATENCY and rotates/extends its output from the width controls.
module tb_load_store_unit;

   localparam int RL = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [63:0] req_base = 64'd0;
   logic [63:0] req_offset = 64'd0;
   logic [63:0] req_store_data = 64'd0;
   logic [4:0]  req_rd = 5'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_fault;
   logic        mem_en;
   logic        mem_wea;
   logic [63:0] mem_addr;
   logic [63:0] mem_din;
   logic [1:0]  mem_bit_width;
   logic        mem_sign_extend;
   logic [63:0] mem_dout;

   load_store_unit #(.READ_LATENCY(RL), .ADDR_BITS(20)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_is_store(req_is_store), .req_funct3(req_funct3),
      .req_base(req_base), .req_offset(req_offset),
      .req_store_data(req_store_data), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_rd(resp_rd), .resp_fault(resp_fault),
      .mem_en(mem_en), .mem_wea(mem_wea), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_bit_width(mem_bit_width),
      .mem_sign_extend(mem_sign_extend), .mem_dout(mem_dout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memory model
   logic [7:0] mem [0:1023] = '{default: 8'h00};
   int lat_cnt = 0;
   logic [63:0] raw;
   logic [63:0] ext;

   always @(posedge clk) begin
      lat_cnt <= mem_en ? lat_cnt + 1 : 0;
      if (mem_en && mem_wea)
         for (int i = 0; i < (1 << mem_bit_width); i++)
            mem[10'(mem_addr + 64'(i))] <= mem_din[8*i +: 8];
   end

   always_comb begin
      raw = 64'd0;
      ext = 64'd0;
      for (int i = 0; i < 8; i++)
         if (i < (1 << mem_bit_width)) raw[8*i +: 8] = mem[10'(mem_addr + 64'(i))];
      case (mem_bit_width)
         2'd0: ext = mem_sign_extend ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
         2'd1: ext = mem_sign_extend ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
         2'd2: ext = mem_sign_extend ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
         default: ext = raw;
      endcase
      mem_dout = (lat_cnt >= RL) ? ext : 64'hDEAD_DEAD_DEAD_DEAD;
   end

   // scoreboard
   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        fault;
      int          cyc;
   } exp_t;
   exp_t q[$];

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   int wea_cnt = 0;
   int en_cnt = 0;
   logic [63:0] wr_addr = 64'd0;
   logic [1:0]  wr_bw = 2'd0;
   logic [63:0] rd_addr = 64'd0;
   bit seen = 0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (resp_valid && !seen) begin
            seen = 1;
            if (q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_resp: got rd=%0d data=%h expected no response", resp_rd, resp_data);
            end else begin
               e = q.pop_front();
               chk("resp_data", resp_data, e.data);
               chk("resp_rd", 64'(resp_rd), 64'(e.rd));
               chk("resp_fault", 64'(resp_fault), 64'(e.fault));
               chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (mem_en) en_cnt++;
         if (mem_en && mem_wea) begin
            wea_cnt++;
            wr_addr = mem_addr;
            wr_bw   = mem_bit_width;
         end
         if (mem_en && !mem_wea) rd_addr = mem_addr;
      end
      if (!resp_valid) seen = 0;
   end

   task automatic issue(input bit st, input logic [2:0] f3, input logic [63:0] base,
                        input logic [63:0] off, input logic [63:0] sd, input logic [4:0] rd,
                        input bit push, input logic [63:0] ed, input bit ef, input int lat);
      exp_t e;
      int k;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) begin
         n_total++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
      end
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_base = base;
      req_offset = off; req_store_data = sd; req_rd = rd;
      if (push) begin
         e.data = ed; e.rd = rd; e.fault = ef; e.cyc = cyc + lat;
         q.push_back(e);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      @(negedge clk); #1;
      while (!(q.size() == 0 && req_ready) && k < 60) begin
         @(negedge clk); #1;
         k++;
      end
      if (!(q.size() == 0 && req_ready)) begin
         n_total++;
         $display("FAIL drain_timeout: got pending=%0d expected 0", q.size());
      end
   endtask

   localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;
   localparam logic [63:0] DW   = 64'h1122_3344_5566_7788;
   localparam logic [63:0] DW2  = 64'hCAFE_F00D_1234_5678;

   initial begin
      int en0, wea0, k;

      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_resp", {resp_valid, resp_fault, resp_rd, mem_en, mem_wea, mem_bit_width, mem_sign_extend}, 64'd0);
      chk("rst_data", resp_data | mem_addr | mem_din, 64'd0);
      rst = 1'b0;
      #1 chk("ready_after_rst", 64'(req_ready), 64'd1);

      // misaligned SD then LD
      issue(1, 3'b011, 64'h100, 64'd3, DW, 5'd1, 1, 64'd0, 0, 2);
      wait_done();
      chk("sd_wea_cycles", 64'(wea_cnt), 64'd1);
      chk("sd_addr", wr_addr, 64'h103);
      chk("sd_bw", 64'(wr_bw), 64'd3);
      issue(0, 3'b011, 64'h100, 64'd3, 64'd0, 5'd5, 1, DW, 0, 2 + RL);
      wait_done();

      // sign extension; store data carries junk above the stored byte
      issue(1, 3'b000, 64'h40, 64'd0, 64'h1234_5680, 5'd2, 1, 64'd0, 0, 2);
      issue(0, 3'b000, 64'h40, 64'd0, 64'd0, 5'd6, 1, 64'hFFFF_FFFF_FFFF_FF80, 0, 2 + RL);
      issue(0, 3'b100, 64'h40, 64'd0, 64'd0, 5'd7, 1, 64'h80, 0, 2 + RL);
      issue(0, 3'b101, 64'h40, 64'd0, 64'd0, 5'd8, 1, 64'h80, 0, 2 + RL);
      wait_done();

      // negative offset
      issue(1, 3'b010, 64'h0, 64'h8, 64'h8000_0001, 5'd3, 1, 64'd0, 0, 2);
      issue(0, 3'b010, 64'h10, NEG8, 64'd0, 5'd9, 1, 64'hFFFF_FFFF_8000_0001, 0, 2 + RL);
      wait_done();
      chk("neg_off_addr", rd_addr, 64'h8);

      // last legal word, then faults
      issue(0, 3'b110, 64'hFFFFC, 64'd0, 64'd0, 5'd10, 1, 64'd0, 0, 2 + RL);
      wait_done();
      en0 = en_cnt;
      issue(0, 3'b010, 64'hFFFFE, 64'd0, 64'd0, 5'd14, 1, 64'd0, 1, 1);
      issue(0, 3'b111, 64'h40, 64'd0, 64'd0, 5'd15, 1, 64'd0, 1, 1);
      issue(1, 3'b100, 64'h40, 64'd0, 64'hFF, 5'd16, 1, 64'd0, 1, 1);
      issue(0, 3'b000, 64'h10, 64'hFFFF_FFFF_FFFF_FFE0, 64'd0, 5'd17, 1, 64'd0, 1, 1);
      wait_done();
      chk("fault_no_mem_en", 64'(en_cnt), 64'(en0));

      // backpressure
      resp_ready = 1'b0;
      wea0 = wea_cnt;
      issue(0, 3'b011, 64'h100, 64'd3, 64'd0, 5'd11, 1, DW, 0, 2 + RL);
      k = 0;
      while (!resp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 64'(resp_valid), 64'd1);
         chk("bp_data", resp_data, DW);
         chk("bp_rd", 64'(resp_rd), 64'd11);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         if (i == 1) begin
            req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b011;
            req_base = 64'h300; req_offset = 64'd0; req_store_data = 64'hBAD; req_rd = 5'd20;
         end
         if (i == 2) req_valid = 1'b0;
      end
      resp_ready = 1'b1;
      wait_done();
      repeat (6) @(negedge clk);
      chk("bp_pulse_ignored", 64'(wea_cnt), 64'(wea0));

      // reset during WAIT
      issue(0, 3'b011, 64'h100, 64'd3, 64'd0, 5'd12, 0, 64'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_wait_ready_in_rst", 64'(req_ready), 64'd0);
      rst = 1'b0;
      #1 chk("rst_wait_ready", 64'(req_ready), 64'd1);
      repeat (8) @(negedge clk);
      chk("rst_wait_no_resp", 64'(resp_valid), 64'd0);

      // reset during store ISSUE still commits the write
      issue(1, 3'b011, 64'h200, 64'd0, DW2, 5'd13, 0, 64'd0, 0, 0);
      @(negedge clk);
      chk("rst_issue_wea", 64'(mem_wea), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_issue_no_resp", 64'(resp_valid), 64'd0);
      issue(0, 3'b011, 64'h200, 64'd0, 64'd0, 5'd18, 1, DW2, 0, 2 + RL);
      wait_done();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
